if_fetch_unit: RTL

Parametrised instruction fetch stage for the veriRISCV core. It replaces the single-register fetch stage with a credit-controlled fetch engine: it issues reads to the synchronous instruction RAM, buffers returned words with their PCs in a small FIFO, and presents them to ID through a valid/ready handshake. It also supports back-pressure from ID and PC redirection from the branch/jump unit, with flush of buffered and in-flight fetches.

---
 rtl/if_fetch_unit.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Credit-controlled instruction fetch stage: issues reads to a 1-cycle synchronous
// instruction RAM, buffers {pc, instr} pairs in a small FIFO and hands them to ID
// over valid/ready. Define IF_FETCH_BYPASS_EN to forward responses straight to ID
// when the buffer is empty (saves one cycle of fetch latency).
module if_fetch_unit #(
    parameter int              PC_W      = 32,
    parameter int              ADDR_W    = 12,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] instr_ram_addr,
    output logic              instr_ram_rd,
    input  logic [31:0]       instr_ram_din,
    input  logic              branch_take,
    input  logic [PC_W-1:0]   branch_pc,
    input  logic              id_ready,
    output logic              if2id_valid,
    output logic [PC_W-1:0]   if2id_pc,
    output logic [31:0]       if2id_instruction
);

    localparam int PTR_W = $clog2(BUF_DEPTH);

    // One bit wider than a pointer so occupancy + inflight never wraps.
    typedef logic [PTR_W+1:0] credit_t;

    logic [PC_W-1:0]  fetch_pc;
    logic [PC_W-1:0]  req_pc;
    logic             inflight;
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W:0]   count;

    logic [PC_W-1:0]  pc_mem    [BUF_DEPTH];
    logic [31:0]      instr_mem [BUF_DEPTH];

    logic             fifo_empty;
    logic             fifo_full;
    logic             resp_valid;
    logic             push;
    logic             fifo_pop;
    logic             pop;
    logic             issue;
    credit_t          credit;
    logic [PC_W-1:0]  branch_target;
    logic [PC_W-1:0]  head_pc;
    logic [31:0]      head_instr;

    assign count         = wr_ptr - rd_ptr;
    assign fifo_empty    = (wr_ptr == rd_ptr);
    assign fifo_full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                           (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign branch_target = branch_pc & ~PC_W'(3);
    assign head_pc       = pc_mem[rd_ptr[PTR_W-1:0]];
    assign head_instr    = instr_mem[rd_ptr[PTR_W-1:0]];

    // A response landing in a redirect cycle belongs to the old path: drop it.
    assign resp_valid = inflight && !branch_take;

`ifdef IF_FETCH_BYPASS_EN
    logic bypass_hit;

    assign bypass_hit = resp_valid && fifo_empty;
    assign push       = resp_valid && !(bypass_hit && id_ready);
    assign fifo_pop   = !fifo_empty && id_ready;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        if2id_valid       = 1'b0;
        if2id_pc          = '0;
        if2id_instruction = '0;
        if (!fifo_empty) begin
            if2id_valid       = 1'b1;
            if2id_pc          = head_pc;
            if2id_instruction = head_instr;
        end else if (bypass_hit) begin
            if2id_valid       = 1'b1;
            if2id_pc          = req_pc;
            if2id_instruction = instr_ram_din;
        end
    end
`else
    assign push     = resp_valid;
    assign fifo_pop = !fifo_empty && id_ready;

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        if2id_valid       = 1'b0;
        if2id_pc          = '0;
        if2id_instruction = '0;
        if (!fifo_empty) begin
            if2id_valid       = 1'b1;
            if2id_pc          = head_pc;
            if2id_instruction = head_instr;
        end
    end
`endif

    assign pop = if2id_valid && id_ready;

    // Buffered + in-flight words after this cycle's pop must leave room for one more read.
    assign credit = credit_t'(count) + credit_t'(inflight) - credit_t'(pop);
    assign issue  = !rst && !branch_take && (credit < credit_t'(BUF_DEPTH));

    assign instr_ram_rd   = issue;
    assign instr_ram_addr = fetch_pc[ADDR_W+1:2];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (branch_take) begin
                fetch_pc <= branch_target;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
            end else begin
                if (issue)    fetch_pc <= fetch_pc + PC_W'(4);
                if (push)     wr_ptr   <= wr_ptr + 1'b1;
                if (fifo_pop) rd_ptr   <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: buffer storage and the request PC are not reset; the pointers and inflight flag qualify them.
    always_ff @(posedge clk) begin
        if (issue) req_pc <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr[PTR_W-1:0]]    <= req_pc;
            instr_mem[wr_ptr[PTR_W-1:0]] <= instr_ram_din;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        push |-> (!fifo_full || fifo_pop));

    a_hold_stable : assert property (@(posedge clk) disable iff (rst)
        (if2id_valid && !id_ready && !branch_take) |=>
            (if2id_valid && $stable(if2id_pc) && $stable(if2id_instruction)));

endmodule
